// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared NAND full-adder cell stepped N times,
// LSB first, with a start/ready handshake and a one-cycle done pulse.

module full_adder_nand (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  logic w_n1, w_n2, w_n3, w_x;
  logic w_n4, w_n5, w_n6;

  // Classic nine-NAND full adder
  assign w_n1 = ~(i_a & i_b);
  assign w_n2 = ~(i_a & w_n1);
  assign w_n3 = ~(i_b & w_n1);
  assign w_x  = ~(w_n2 & w_n3);
  assign w_n4 = ~(w_x & i_c);
  assign w_n5 = ~(w_x & w_n4);
  assign w_n6 = ~(i_c & w_n4);
  assign o_s  = ~(w_n5 & w_n6);
  assign o_co = ~(w_n4 & w_n1);
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_s_sr;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sum;
  logic          r_cout;

  logic          w_load;
  logic          w_step;
  logic          w_last;
  logic          w_fa_s;
  logic          w_fa_co;
  logic [N-1:0]  w_s_shift;

  full_adder_nand u_fa (
    .i_a  (r_a_sr[0]),
    .i_b  (r_b_sr[0]),
    .i_c  (r_carry),
    .o_s  (w_fa_s),
    .o_co (w_fa_co)
  );

  // Sum bits enter at the MSB so the word is aligned after N shifts
  generate
    if (N == 1) begin : g_s1
      assign w_s_shift = w_fa_s;
    end else begin : g_sn
      assign w_s_shift = {w_fa_s, r_s_sr[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done_tick   = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        w_step = 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_tick   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_s_sr  <= '0;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_s_sr  <= w_s_shift;
      r_carry <= w_fa_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_s_shift;
        r_cout <= w_fa_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer that time-shares one full_adder_nand cell to add two N-bit operands, one bit per clock, LSB first.
- Holds the operands in shift registers and the carry in a flip-flop, steps the cell N times, then presents the result with a one-cycle completion pulse.
- Sits between a requesting datapath (start/ready handshake) and the single shared full-adder resource.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock, rising-edge active
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when ready=1
- a  input  N  operand A; captured at the accepted start edge
- b  input  N  operand B; captured at the accepted start edge
- cin  input  1  carry-in; captured at the accepted start edge
- ready  output  1  high in IDLE; indicates a start will be accepted
- done_tick  output  1  one-cycle pulse when sum and cout become valid
- sum  output  N  registered result; held until the next completion
- cout  output  1  registered final carry; held with sum

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values, applied immediately on reset_n=0: state=IDLE, ready=1, done_tick=0, sum=0, cout=0, bit counter=0, internal shift registers=0, carry flip-flop=0.
- Exactly one full_adder_nand instance is used. Its inputs are the LSB of the A shift register, the LSB of the B shift register, and the carry flip-flop. No other adder logic is permitted.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - ready=1.
  - When start=1 at edge E0: load A_sr=a, B_sr=b, carry=cin, S_sr=0, count=0; go to ADD.
  - When start=0: remain in IDLE.
- ADD:
  - ready=0.
  - At each edge: shift the cell's s output into the MSB of S_sr (S_sr shifts right); shift A_sr and B_sr right by one; carry<=cell cout; count<=count+1.
  - At the edge where count==N-1 (edge EN): also load sum<=the fully shifted S_sr value (including the current bit) and cout<=cell cout; go to DONE.
  - Exactly N ADD edges occur, E1 through EN.
- DONE:
  - ready=0, done_tick=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: done_tick is high in the cycle following edge EN, which is N+1 edges after the accepted start edge E0. The next start can be accepted at edge EN+2, giving a throughput of one operation per N+2 cycles.
- start while ready=0 (ADD or DONE) is ignored. It has no effect on the operation in flight and is not queued.
- Changes to a, b and cin after E0 do not affect the result.
- sum and cout change only at EN. Between operations they hold the last result, or 0 after reset.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(N+1), computed exactly. No overflow signalling beyond cout.
- Counter width is max(1, clog2(N)).
- N=1: ADD lasts one edge; done_tick appears two edges after start.
- Reset asserted mid-ADD or in DONE aborts the operation and forces all reset values. No done_tick is produced for the aborted operation.
- Reset deassertion is followed by normal IDLE operation on the next edge.

Test Plan:
- N=8, a=8'h5A, b=8'h3C, cin=0, start at E0 -> done_tick high only in the cycle after E8; sum=8'h96, cout=0; ready low from E0 to E9, high again after E9.
- N=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=0, b=0, cin=0 -> sum=0, cout=0.
- Start held high continuously with a=8'h01, b=8'h02 and operands changed each cycle after E0 -> the first result is sum=8'h03. Starts during ADD/DONE are ignored. A new operation begins only at E10 (ready=1), with done_tick spacing of exactly 10 cycles.
- reset_n pulsed low after 4 ADD edges of a=8'hAA+b=8'h55 -> outputs return immediately to ready=1, sum=0, cout=0, done_tick=0; no done_tick follows. A subsequent 8'h10+8'h20 gives sum=8'h30.
- N=1 instance, all 8 combinations of a, b, cin -> {cout,sum} matches the full-adder truth table (e.g. 1,1,1 -> cout=1, sum=1); done_tick appears 2 edges after each start.
- Randomised N=8: 200 operations compared against a behavioural a+b+cin model. sum and cout must stay stable between completions.
